// File: rtl/fp_special_screen_pkg.sv
// Shared types for the add/sub operand pre-screen: special-result codes and
// operand classes.
package addpkg;

   typedef enum logic [1:0] {
      NO_ERR   = 2'd0,
      ZERO_ERR = 2'd1,
      NAN_ERR  = 2'd2,
      INF_ERR  = 2'd3
   } i_err_t;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } fp_class_t;

   function automatic logic cls_is_nan(input fp_class_t c);
      return (c == CLS_QNAN) || (c == CLS_SNAN);
   endfunction

endpackage

// File: rtl/fp_special_screen_classify.sv
// Combinational per-operand classifier: class, remapped exponent and
// mantissa with the hidden bit prepended.
module fp_classify
   import addpkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W-1:0] i_exp,
   input  logic [MAN_W-1:0] i_man,
   output fp_class_t        o_class,
   output logic [EXP_W-1:0] o_exp_d,
   output logic [MAN_W:0]   o_man_x
);

   logic w_exp_zero;
   logic w_exp_ones;
   logic w_man_zero;

   assign w_exp_zero = ~|i_exp;
   assign w_exp_ones = &i_exp;
   assign w_man_zero = ~|i_man;

   always_comb begin
      o_class = CLS_NORM;
      o_exp_d = i_exp;
      o_man_x = {1'b1, i_man};
      if (w_exp_zero) begin
         o_man_x = {1'b0, i_man};
         if (w_man_zero) begin
            o_class = CLS_ZERO;
            o_exp_d = '0;
         end else begin
            // subnormals share the minimum normal exponent
            o_class = CLS_SUB;
            o_exp_d = EXP_W'(1);
         end
      end else if (w_exp_ones) begin
         if (w_man_zero)
            o_class = CLS_INF;
         else if (i_man[MAN_W-1])
            o_class = CLS_QNAN;
         else
            o_class = CLS_SNAN;
      end
   end

endmodule

// File: rtl/fp_special_screen.sv
// Two-stage valid/ready operand pre-screen for the FP add/sub datapath.
// Optional sticky exception flags are built when FP_SCREEN_FLAGS_EN is defined.
module fp_special_screen
   import addpkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   complement,
   input  logic [EXP_W+MAN_W:0]   op_a,
   input  logic [EXP_W+MAN_W:0]   op_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   sign_a,
   output logic                   sign_b,
   output logic [EXP_W-1:0]       exp_a_d,
   output logic [EXP_W-1:0]       exp_b_d,
   output logic [MAN_W:0]         man_a,
   output logic [MAN_W:0]         man_b,
   output fp_class_t              class_a,
   output fp_class_t              class_b,
   output i_err_t                 err
`ifdef FP_SCREEN_FLAGS_EN
   ,
   input  logic                   flag_clr,
   output logic [2:0]             flags
`endif
);

   localparam int SB = EXP_W + MAN_W;

   fp_class_t        w_cls_a, w_cls_b;
   logic [EXP_W-1:0] w_exp_a, w_exp_b;
   logic [MAN_W:0]   w_man_a, w_man_b;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .i_exp   (op_a[SB-1:MAN_W]),
      .i_man   (op_a[MAN_W-1:0]),
      .o_class (w_cls_a),
      .o_exp_d (w_exp_a),
      .o_man_x (w_man_a)
   );

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .i_exp   (op_b[SB-1:MAN_W]),
      .i_man   (op_b[MAN_W-1:0]),
      .o_class (w_cls_b),
      .o_exp_d (w_exp_b),
      .o_man_x (w_man_b)
   );

   // S1: operand fields (adjusted form is a 1:1 remap of the raw fields), classes
   logic             r_live;
   logic             r_s1_valid;
   logic             r_s1_comp;
   logic             r_s1_sign_a, r_s1_sign_b;
   logic [EXP_W-1:0] r_s1_exp_a, r_s1_exp_b;
   logic [MAN_W:0]   r_s1_man_a, r_s1_man_b;
   fp_class_t        r_s1_cls_a, r_s1_cls_b;

   // S2: resolved result
   logic             r_s2_valid;
   logic             r_s2_sign_a, r_s2_sign_b;
   logic [EXP_W-1:0] r_s2_exp_a, r_s2_exp_b;
   logic [MAN_W:0]   r_s2_man_a, r_s2_man_b;
   fp_class_t        r_s2_cls_a, r_s2_cls_b;
   i_err_t           r_s2_err;

   logic   w_s1_adv;
   logic   w_acc;
   logic   w_s2_ld;
   logic   w_inf_a, w_inf_b, w_inf_sub;
   logic   w_invalid;
   i_err_t w_err;

   assign w_s1_adv = !r_s2_valid || out_ready;
   assign in_ready = r_live && (!r_s1_valid || w_s1_adv);
   assign w_acc    = in_valid && in_ready;
   assign w_s2_ld  = r_s1_valid && w_s1_adv;

   assign w_inf_a   = (r_s1_cls_a == CLS_INF);
   assign w_inf_b   = (r_s1_cls_b == CLS_INF);
   assign w_inf_sub = w_inf_a && w_inf_b && r_s1_comp;
   assign w_invalid = w_inf_sub || (r_s1_cls_a == CLS_SNAN) || (r_s1_cls_b == CLS_SNAN);

   always_comb begin
      w_err = NO_ERR;
      if (cls_is_nan(r_s1_cls_a) || cls_is_nan(r_s1_cls_b) || w_inf_sub)
         w_err = NAN_ERR;
      else if (w_inf_a || w_inf_b)
         w_err = INF_ERR;
      else if ((r_s1_cls_a == CLS_ZERO) && (r_s1_cls_b == CLS_ZERO))
         w_err = ZERO_ERR;
      else if ((r_s1_exp_a == r_s1_exp_b) && (r_s1_man_a == r_s1_man_b) && r_s1_comp)
         w_err = ZERO_ERR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live      <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_comp   <= 1'b0;
         r_s1_sign_a <= 1'b0;
         r_s1_sign_b <= 1'b0;
         r_s1_exp_a  <= '0;
         r_s1_exp_b  <= '0;
         r_s1_man_a  <= '0;
         r_s1_man_b  <= '0;
         r_s1_cls_a  <= CLS_ZERO;
         r_s1_cls_b  <= CLS_ZERO;
      end else begin
         r_live <= 1'b1;
         if (in_ready)
            r_s1_valid <= in_valid;
         if (w_acc) begin
            r_s1_comp   <= complement;
            r_s1_sign_a <= op_a[SB];
            r_s1_sign_b <= op_b[SB];
            r_s1_exp_a  <= w_exp_a;
            r_s1_exp_b  <= w_exp_b;
            r_s1_man_a  <= w_man_a;
            r_s1_man_b  <= w_man_b;
            r_s1_cls_a  <= w_cls_a;
            r_s1_cls_b  <= w_cls_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_sign_a <= 1'b0;
         r_s2_sign_b <= 1'b0;
         r_s2_exp_a  <= '0;
         r_s2_exp_b  <= '0;
         r_s2_man_a  <= '0;
         r_s2_man_b  <= '0;
         r_s2_cls_a  <= CLS_ZERO;
         r_s2_cls_b  <= CLS_ZERO;
         r_s2_err    <= NO_ERR;
      end else begin
         if (w_s1_adv)
            r_s2_valid <= r_s1_valid;
         if (w_s2_ld) begin
            r_s2_sign_a <= r_s1_sign_a;
            r_s2_sign_b <= r_s1_sign_b;
            r_s2_exp_a  <= r_s1_exp_a;
            r_s2_exp_b  <= r_s1_exp_b;
            r_s2_man_a  <= r_s1_man_a;
            r_s2_man_b  <= r_s1_man_b;
            r_s2_cls_a  <= r_s1_cls_a;
            r_s2_cls_b  <= r_s1_cls_b;
            r_s2_err    <= w_err;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign sign_a    = r_s2_sign_a;
   assign sign_b    = r_s2_sign_b;
   assign exp_a_d   = r_s2_exp_a;
   assign exp_b_d   = r_s2_exp_b;
   assign man_a     = r_s2_man_a;
   assign man_b     = r_s2_man_b;
   assign class_a   = r_s2_cls_a;
   assign class_b   = r_s2_cls_b;
   assign err       = r_s2_err;

`ifdef FP_SCREEN_FLAGS_EN
   logic       r_s2_inv;
   logic [2:0] r_flags;
   logic [2:0] w_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_s2_inv <= 1'b0;
      else if (w_s2_ld)
         r_s2_inv <= w_invalid;
   end

   always_comb begin
      w_set = 3'b000;
      if (r_s2_valid && out_ready)
         w_set = {r_s2_inv, r_s2_err == INF_ERR, r_s2_err == ZERO_ERR};
   end

   // a set event in the clearing cycle survives the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_flags <= 3'b000;
      else
         r_flags <= (flag_clr ? 3'b000 : r_flags) | w_set;
   end

   assign flags = r_flags;
`else
   logic w_unused;
   assign w_unused = w_invalid;
`endif

endmodule
